// File: rtl/msdap_out_serializer.sv
// ---------------------------------------------------------------------------
// msdap_out_serializer
//   Output-side transmitter for the MSDAP datapath. Takes 40-bit left/right
//   filter results as parallel words and shifts them out MSB-first on a
//   bit-serial link, with a one-bit frame marker on the MSB period. Bit timing
//   comes from a free-running sClk divider. A single holding register lets
//   the next word start immediately after the current LSB, with no idle bit.
//
// Ports
//   sClk        system clock
//   reset_n     asynchronous active-low reset
//   in_valid    parallel word offered
//   in_ready    holding register empty (word taken on in_valid && in_ready)
//   in_data_l   left-channel word
//   in_data_r   right-channel word
//   flush       synchronous abort: drops held and in-flight words
//   ser_clk     serial bit clock; receiver samples on its falling edge
//   frame       high during the MSB bit period of each word
//   out_bit_l   left serial data
//   out_bit_r   right serial data
//   busy        holding register full or a word is being shifted
//   words_sent  count of completely transmitted words (wraps)
// ---------------------------------------------------------------------------
module msdap_out_serializer #(
   parameter int WORD_W  = 40,
   parameter int CLK_DIV = 35
) (
   input  logic              sClk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data_l,
   input  logic [WORD_W-1:0] in_data_r,
   input  logic              flush,
   output logic              ser_clk,
   output logic              frame,
   output logic              out_bit_l,
   output logic              out_bit_r,
   output logic              busy,
   output logic [15:0]       words_sent
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int BIT_W = $clog2(WORD_W);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);
   localparam logic [BIT_W-1:0] BIT_ZERO = {BIT_W{1'b0}};

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   logic [DIV_W-1:0]  div_cnt_r;
   logic              bit_tick_s;
   state_t            state_r;
   logic              hold_full_r;
   logic [WORD_W-1:0] hold_l_r;
   logic [WORD_W-1:0] hold_r_r;
   // The MSB goes straight to the output on load, so the shifters only keep
   // the remaining WORD_W-1 bits.
   logic [WORD_W-2:0] shift_l_r;
   logic [WORD_W-2:0] shift_r_r;
   logic [BIT_W-1:0]  bit_cnt_r;
   logic [15:0]       words_sent_r;
   logic              frame_r;
   logic              out_l_r;
   logic              out_r_r;

   // Bit tick and serial clock are decoded from the divider; ser_clk is high
   // for the first CLK_DIV/2 cycles of each bit, so data launched on the
   // tick is mid-bit at the falling edge.
   assign bit_tick_s = (div_cnt_r == DIV_LAST);
   assign ser_clk    = (div_cnt_r < DIV_HALF);

   assign in_ready   = ~hold_full_r;
   assign busy       = hold_full_r | (state_r == ST_SHIFT);
   assign frame      = frame_r;
   assign out_bit_l  = out_l_r;
   assign out_bit_r  = out_r_r;
   assign words_sent = words_sent_r;

   // Free-running bit divider; flush deliberately leaves it alone so the
   // link keeps a steady bit clock.
   always_ff @(posedge sClk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt_r <= {DIV_W{1'b0}};
      end else if (bit_tick_s) begin
         div_cnt_r <= {DIV_W{1'b0}};
      end else begin
         div_cnt_r <= div_cnt_r + DIV_W'(1);
      end
   end

   // Holding register, transmit FSM, shifters and registered serial outputs.
   // Accept needs hold_full=0 and a load needs hold_full=1, so the set and
   // clear of hold_full can never collide on one edge.
   always_ff @(posedge sClk or negedge reset_n) begin
      if (!reset_n) begin
         state_r      <= ST_IDLE;
         hold_full_r  <= 1'b0;
         hold_l_r     <= {WORD_W{1'b0}};
         hold_r_r     <= {WORD_W{1'b0}};
         shift_l_r    <= {(WORD_W-1){1'b0}};
         shift_r_r    <= {(WORD_W-1){1'b0}};
         bit_cnt_r    <= BIT_ZERO;
         words_sent_r <= 16'd0;
         frame_r      <= 1'b0;
         out_l_r      <= 1'b0;
         out_r_r      <= 1'b0;
      end else if (flush) begin
         // Abort wins over accept and over the bit tick; the partial word
         // is not counted.
         state_r     <= ST_IDLE;
         hold_full_r <= 1'b0;
         bit_cnt_r   <= BIT_ZERO;
         frame_r     <= 1'b0;
         out_l_r     <= 1'b0;
         out_r_r     <= 1'b0;
      end else begin
         if (in_valid && !hold_full_r) begin
            hold_l_r    <= in_data_l;
            hold_r_r    <= in_data_r;
            hold_full_r <= 1'b1;
         end

         if (bit_tick_s) begin
            case (state_r)
               ST_IDLE: begin
                  if (hold_full_r) begin
                     shift_l_r   <= hold_l_r[WORD_W-2:0];
                     shift_r_r   <= hold_r_r[WORD_W-2:0];
                     out_l_r     <= hold_l_r[WORD_W-1];
                     out_r_r     <= hold_r_r[WORD_W-1];
                     frame_r     <= 1'b1;
                     bit_cnt_r   <= BIT_LAST;
                     hold_full_r <= 1'b0;
                     state_r     <= ST_SHIFT;
                  end else begin
                     frame_r <= 1'b0;
                     out_l_r <= 1'b0;
                     out_r_r <= 1'b0;
                  end
               end
               ST_SHIFT: begin
                  if (bit_cnt_r != BIT_ZERO) begin
                     out_l_r   <= shift_l_r[WORD_W-2];
                     out_r_r   <= shift_r_r[WORD_W-2];
                     shift_l_r <= {shift_l_r[WORD_W-3:0], 1'b0};
                     shift_r_r <= {shift_r_r[WORD_W-3:0], 1'b0};
                     frame_r   <= 1'b0;
                     bit_cnt_r <= bit_cnt_r - BIT_W'(1);
                  end else begin
                     // End of the LSB period: count it and chain straight
                     // into the held word if there is one.
                     words_sent_r <= words_sent_r + 16'd1;
                     if (hold_full_r) begin
                        shift_l_r   <= hold_l_r[WORD_W-2:0];
                        shift_r_r   <= hold_r_r[WORD_W-2:0];
                        out_l_r     <= hold_l_r[WORD_W-1];
                        out_r_r     <= hold_r_r[WORD_W-1];
                        frame_r     <= 1'b1;
                        bit_cnt_r   <= BIT_LAST;
                        hold_full_r <= 1'b0;
                     end else begin
                        frame_r <= 1'b0;
                        out_l_r <= 1'b0;
                        out_r_r <= 1'b0;
                        state_r <= ST_IDLE;
                     end
                  end
               end
               default: begin
                  frame_r   <= 1'b0;
                  out_l_r   <= 1'b0;
                  out_r_r   <= 1'b0;
                  bit_cnt_r <= BIT_ZERO;
                  state_r   <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_msdap_out_serializer.sv
// ---------------------------------------------------------------------------
// tb_msdap_out_serializer
//   Two instances: CLK_DIV=4 for framing, flow control, flush and reset, and
//   CLK_DIV=35 for bit phase and ser_clk duty. Monitors rebuild words from
//   ser_clk falling-edge samples and compare against a queue of accepted words.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_msdap_out_serializer;

   localparam int W   = 40;
   localparam int C4  = 4;
   localparam int C35 = 35;

   typedef struct packed {
      logic [W-1:0] l;
      logic [W-1:0] r;
   } word_t;

   logic sClk = 1'b0;
   logic reset_n = 1'b0;

   logic v4 = 1'b0, flush4 = 1'b0;
   logic [W-1:0] l4 = '0, r4 = '0;
   logic rdy4, sck4, frm4, bl4, br4, busy4;
   logic [15:0] ws4;

   logic v35 = 1'b0, flush35 = 1'b0;
   logic [W-1:0] l35 = '0, r35 = '0;
   logic rdy35, sck35, frm35, bl35, br35, busy35;
   logic [15:0] ws35;

   msdap_out_serializer #(.WORD_W(W), .CLK_DIV(C4)) dut4 (
      .sClk(sClk), .reset_n(reset_n), .in_valid(v4), .in_ready(rdy4),
      .in_data_l(l4), .in_data_r(r4), .flush(flush4), .ser_clk(sck4),
      .frame(frm4), .out_bit_l(bl4), .out_bit_r(br4), .busy(busy4),
      .words_sent(ws4));

   msdap_out_serializer #(.WORD_W(W), .CLK_DIV(C35)) dut35 (
      .sClk(sClk), .reset_n(reset_n), .in_valid(v35), .in_ready(rdy35),
      .in_data_l(l35), .in_data_r(r35), .flush(flush35), .ser_clk(sck35),
      .frame(frm35), .out_bit_l(bl35), .out_bit_r(br35), .busy(busy35),
      .words_sent(ws35));

   always #5 sClk = ~sClk;

   int n_cmp = 0;
   int n_err = 0;
   int ecnt;
   word_t exp4[$];
   word_t exp35[$];
   int accepted4 = 0;
   int dropped4 = 0;
   int rise_cnt = 0;
   int last_rise = 0;
   bit have_prev = 1'b0;
   bit spacing_en = 1'b0;
   int col4 = 0;
   bit coll4 = 1'b0;

   // Edge number since reset release: edge n is a bit tick when n % CLK_DIV == 0.
   always @(posedge sClk or negedge reset_n) begin
      if (!reset_n) ecnt <= 0;
      else          ecnt <= ecnt + 1;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] rnd40();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[W-1:0];
   endfunction

   task automatic send4(input logic [W-1:0] l, input logic [W-1:0] r, output int acc_edge);
      bit rdy;
      bit done;
      word_t w;
      done = 1'b0;
      v4 = 1'b1; l4 = l; r4 = r;
      for (int i = 0; i < 2000 && !done; i++) begin
         rdy = rdy4;
         @(posedge sClk); #1;
         if (rdy) done = 1'b1;
      end
      v4 = 1'b0;
      acc_edge = ecnt;
      if (!done) begin
         check("accept_timeout", 64'd0, 64'd1);
      end else begin
         w.l = l; w.r = r;
         exp4.push_back(w);
         accepted4++;
         check("in_ready_after_accept", {63'd0, rdy4}, 64'd0);
         check("busy_after_accept", {63'd0, busy4}, 64'd1);
      end
   endtask

   task automatic wait_idle4();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 5000 && !done; i++) begin
         @(posedge sClk); #1;
         if (!busy4) done = 1'b1;
      end
      if (!done) check("idle_timeout", 64'd0, 64'd1);
   endtask

   task automatic wait_col4(input int n);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 1000 && !done; i++) begin
         @(posedge sClk); #1;
         if (coll4 && col4 == n) done = 1'b1;
      end
      if (!done) check("bit_wait_timeout", 64'd0, 64'd1);
   endtask

   task automatic wait_rise(input int r0);
      for (int i = 0; i < 200 && rise_cnt == r0; i++) begin
         @(posedge sClk); #1;
      end
      if (rise_cnt == r0) check("frame_rise_timeout", 64'd0, 64'd1);
   endtask

   // Monitor for the CLK_DIV=4 instance: frame width/spacing, word recovery.
   initial begin : mon4
      logic [W-1:0] al, ar;
      logic fp, sp;
      int fhi;
      word_t e;
      al = '0; ar = '0; fp = 1'b0; sp = 1'b1; fhi = 0;
      forever begin
         @(negedge sClk);
         if (!reset_n) begin
            fp = 1'b0; sp = 1'b1; fhi = 0; coll4 = 1'b0; col4 = 0;
         end else begin
            if (frm4) begin
               fhi++;
               if (!fp) begin
                  rise_cnt++;
                  if (spacing_en && have_prev)
                     check("frame_spacing", 64'(ecnt - last_rise), 64'(W * C4));
                  last_rise = ecnt;
                  have_prev = 1'b1;
               end
            end else begin
               if (fp) check("frame_width", 64'(fhi), 64'(C4));
               fhi = 0;
            end
            if (sp && !sck4) begin
               if (frm4) begin
                  al = '0; ar = '0; col4 = 0; coll4 = 1'b1;
               end
               if (coll4) begin
                  al = {al[W-2:0], bl4};
                  ar = {ar[W-2:0], br4};
                  col4++;
                  if (col4 == W) begin
                     coll4 = 1'b0;
                     if (exp4.size() == 0) begin
                        check("word_expected4", 64'd0, 64'd1);
                     end else begin
                        e = exp4.pop_front();
                        check("word_l4", 64'(al), 64'(e.l));
                        check("word_r4", 64'(ar), 64'(e.r));
                     end
                  end
               end
            end
            fp = frm4;
            sp = sck4;
         end
      end
   end

   // Monitor for the CLK_DIV=35 instance: ser_clk duty and word recovery.
   initial begin : mon35
      logic [W-1:0] al, ar;
      logic sp;
      int slen, col;
      bit sval, coll;
      word_t e;
      al = '0; ar = '0; sp = 1'b1; slen = 0; sval = 1'b0; col = 0; coll = 1'b0;
      forever begin
         @(negedge sClk);
         if (!reset_n) begin
            sp = 1'b1; slen = 0; sval = 1'b0; col = 0; coll = 1'b0;
         end else begin
            if (sck35 == sp) begin
               slen++;
            end else begin
               if (sval) begin
                  if (sp) check("ser_clk_high", 64'(slen), 64'd17);
                  else    check("ser_clk_low", 64'(slen), 64'd18);
               end
               slen = 1;
               sval = 1'b1;
            end
            if (sp && !sck35) begin
               if (frm35) begin
                  al = '0; ar = '0; col = 0; coll = 1'b1;
               end
               if (coll) begin
                  al = {al[W-2:0], bl35};
                  ar = {ar[W-2:0], br35};
                  col++;
                  if (col == W) begin
                     coll = 1'b0;
                     if (exp35.size() == 0) begin
                        check("word_expected35", 64'd0, 64'd1);
                     end else begin
                        e = exp35.pop_front();
                        check("word_l35", 64'(al), 64'(e.l));
                        check("word_r35", 64'(ar), 64'(e.r));
                     end
                  end
               end
            end
            sp = sck35;
         end
      end
   end

   initial begin : stim
      int a, r0;
      bit done;
      word_t w;
      #1;
      check("rst_in_ready", {63'd0, rdy4}, 64'd1);
      check("rst_busy", {63'd0, busy4}, 64'd0);
      check("rst_frame", {63'd0, frm4}, 64'd0);
      check("rst_bits", {62'd0, bl4, br4}, 64'd0);
      check("rst_ser_clk", {62'd0, sck4, sck35}, 64'd3);
      check("rst_words", 64'(ws4), 64'd0);
      #22 reset_n = 1'b1;
      @(posedge sClk); #1;

      // Single word from idle.
      r0 = rise_cnt;
      send4(40'h80_0000_0001, 40'h00_0000_0000, a);
      wait_rise(r0);
      check("rise_edge", 64'(last_rise), 64'(((a / C4) + 1) * C4));
      check("rise_latency_in_range", {63'd0, (last_rise - a >= 1) && (last_rise - a <= C4)}, 64'd1);
      wait_idle4();
      check("words_single", 64'(ws4), 64'd1);
      check("busy_after_single", {63'd0, busy4}, 64'd0);

      // Accept on a bit-tick edge: frame must rise one full bit later.
      for (int i = 0; i < 8 && ((ecnt + 1) % C4) != 0; i++) begin
         @(posedge sClk); #1;
      end
      r0 = rise_cnt;
      send4(rnd40(), rnd40(), a);
      wait_rise(r0);
      check("tick_accept_latency", 64'(last_rise - a), 64'(C4));
      wait_idle4();

      // Back-to-back: three words, in_valid held.
      spacing_en = 1'b1; have_prev = 1'b0;
      r0 = rise_cnt;
      for (int k = 0; k < 3; k++) send4(rnd40(), rnd40(), a);
      wait_idle4();
      spacing_en = 1'b0;
      check("b2b_frames", 64'(rise_cnt - r0), 64'd3);
      check("words_b2b", 64'(ws4), 64'(16'(accepted4 - dropped4)));

      // Randomized traffic with random gaps.
      for (int k = 0; k < 12; k++) begin
         repeat ($urandom_range(0, 50)) @(posedge sClk);
         #1;
         send4(rnd40(), rnd40(), a);
      end
      wait_idle4();
      check("words_random", 64'(ws4), 64'(16'(accepted4 - dropped4)));

      // Flush at bit 20 with the holding register full.
      send4(rnd40(), rnd40(), a);
      send4(rnd40(), rnd40(), a);
      wait_col4(20);
      check("hold_full_before_flush", {63'd0, rdy4}, 64'd0);
      flush4 = 1'b1;
      v4 = 1'b1;
      @(posedge sClk); #1;
      flush4 = 1'b0;
      v4 = 1'b0;
      dropped4 += exp4.size();
      exp4.delete();
      coll4 = 1'b0; col4 = 0;
      check("flush_frame", {63'd0, frm4}, 64'd0);
      check("flush_bits", {62'd0, bl4, br4}, 64'd0);
      check("flush_in_ready", {63'd0, rdy4}, 64'd1);
      check("flush_busy", {63'd0, busy4}, 64'd0);
      check("flush_words", 64'(ws4), 64'(16'(accepted4 - dropped4)));
      send4(rnd40(), rnd40(), a);
      wait_idle4();
      check("words_after_flush", 64'(ws4), 64'(16'(accepted4 - dropped4)));

      // CLK_DIV=35 phase check.
      for (int k = 0; k < 3; k++) begin
         w.l = (k == 0) ? 40'hA5_5A5A_A5A5 : rnd40();
         w.r = rnd40();
         v35 = 1'b1; l35 = w.l; r35 = w.r;
         done = 1'b0;
         for (int i = 0; i < 3000 && !done; i++) begin
            if (rdy35) done = 1'b1;
            @(posedge sClk); #1;
         end
         v35 = 1'b0;
         if (!done) check("accept35_timeout", 64'd0, 64'd1);
         else exp35.push_back(w);
      end
      done = 1'b0;
      for (int i = 0; i < 8000 && !done; i++) begin
         @(posedge sClk); #1;
         if (!busy35) done = 1'b1;
      end
      if (!done) check("idle35_timeout", 64'd0, 64'd1);
      check("words35", 64'(ws35), 64'd3);
      check("pending35", 64'(exp35.size()), 64'd0);

      // Asynchronous reset in the middle of a word.
      send4(rnd40(), rnd40(), a);
      wait_col4(10);
      #3 reset_n = 1'b0;
      #1;
      check("arst_frame", {63'd0, frm4}, 64'd0);
      check("arst_bits", {62'd0, bl4, br4}, 64'd0);
      check("arst_words", 64'(ws4), 64'd0);
      check("arst_ser_clk", {63'd0, sck4}, 64'd1);
      check("arst_in_ready", {63'd0, rdy4}, 64'd1);
      check("arst_busy", {63'd0, busy4}, 64'd0);
      exp4.delete();
      exp35.delete();
      accepted4 = 0; dropped4 = 0;
      #12 reset_n = 1'b1;
      @(posedge sClk); #1;
      send4(rnd40(), rnd40(), a);
      wait_idle4();
      check("words_after_reset", 64'(ws4), 64'd1);
      check("pending4", 64'(exp4.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
